// File: rtl/uart_command_receiver_if.sv
// Command bus from the serial receive stage to the SUMP command decoder.
// The receiver drives it (master); the decoder only reads it (slave).
interface uart_command_receiver_if;
    logic [7:0]  op;
    logic [31:0] data;
    logic        execute;
    logic        framing_error;

    modport master (
        output op,
        output data,
        output execute,
        output framing_error
    );

    modport slave (
        input op,
        input data,
        input execute,
        input framing_error
    );
endinterface

// File: rtl/uart_command_receiver.sv
// 8N1 serial receiver that assembles SUMP short (1-byte) and long (opcode + 4 argument bytes)
// commands, timed by the shared trxClock baud enable.
module uart_command_receiver #(
    parameter int FREQ      = 100000000,
    parameter int BAUDRATE  = 115200,
    parameter int BITLENGTH = FREQ / BAUDRATE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          trxClock,
    input  logic                          rx,
    uart_command_receiver_if.master       cmd
);

    localparam logic [9:0] FULL_TICKS = 10'(BITLENGTH);
    localparam logic [9:0] HALF_TICKS = 10'(BITLENGTH / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [1:0]  sync_reg;
    logic        rxs;
    state_t      state_reg;
    logic [9:0]  tick_cnt_reg;
    logic [9:0]  tick_cnt_next;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        byte_valid_reg;
    logic        framing_error_reg;

    logic [2:0]  byte_cnt_reg;
    logic [7:0]  op_hold_reg;
    logic [23:0] arg_reg;
    logic [7:0]  op_reg;
    logic [31:0] data_reg;
    logic        execute_reg;
    logic [3:0]  lane_sel;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rxs           = sync_reg[1];
    assign tick_cnt_next = tick_cnt_reg + 10'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            tick_cnt_reg      <= '0;
            bit_idx_reg       <= '0;
            shift_reg         <= '0;
            byte_valid_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
        end else begin
            byte_valid_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
            if (trxClock) begin
                case (state_reg)
                    S_IDLE: begin
                        if (!rxs) begin
                            state_reg    <= S_START;
                            tick_cnt_reg <= '0;
                        end
                    end
                    S_START: begin
                        if (tick_cnt_next == HALF_TICKS) begin
                            tick_cnt_reg <= '0;
                            bit_idx_reg  <= '0;
                            // A line already back high at mid-start-bit was only a glitch.
                            state_reg    <= rxs ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_next;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt_next == FULL_TICKS) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rxs, shift_reg[7:1]};
                            if (bit_idx_reg == 3'd7) begin
                                state_reg <= S_STOP;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_next;
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt_next == FULL_TICKS) begin
                            tick_cnt_reg      <= '0;
                            state_reg         <= S_IDLE;
                            byte_valid_reg    <= rxs;
                            framing_error_reg <= !rxs;
                        end else begin
                            tick_cnt_reg <= tick_cnt_next;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // lane_sel[i] marks which argument byte the next valid byte fills.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_sel[gi] = (byte_cnt_reg == 3'(gi + 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_reg <= '0;
            op_hold_reg  <= '0;
            arg_reg      <= '0;
            op_reg       <= '0;
            data_reg     <= '0;
            execute_reg  <= 1'b0;
        end else begin
            execute_reg <= 1'b0;
            if (framing_error_reg) begin
                byte_cnt_reg <= '0;
            end else if (byte_valid_reg) begin
                if (byte_cnt_reg == 3'd0) begin
                    if (shift_reg[7]) begin
                        op_hold_reg  <= shift_reg;
                        byte_cnt_reg <= 3'd1;
                    end else begin
                        op_reg      <= shift_reg;
                        data_reg    <= '0;
                        execute_reg <= 1'b1;
                    end
                end else if (lane_sel[3]) begin
                    op_reg       <= op_hold_reg;
                    data_reg     <= {shift_reg, arg_reg};
                    execute_reg  <= 1'b1;
                    byte_cnt_reg <= '0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (lane_sel[i]) begin
                            arg_reg[8*i +: 8] <= shift_reg;
                        end
                    end
                    byte_cnt_reg <= byte_cnt_reg + 3'd1;
                end
            end
        end
    end

    assign cmd.op            = op_reg;
    assign cmd.data          = data_reg;
    assign cmd.execute       = execute_reg;
    assign cmd.framing_error = framing_error_reg;

endmodule
